// File: rtl/idex_hazard_reg_pkg.sv
// Shared pipeline definitions: control-word layout, opcode constants and
// the operand-usage rules that hazard detection relies on.
package idex_hazard_reg_pkg;

    localparam int CTL_W = 9;

    // Control word, MSB first: the field order fixes the bit positions.
    typedef struct packed {
        logic       regwr;     // [8]
        logic       memwr;     // [7]
        logic       memrd;     // [6]
        logic       memtoreg;  // [5]
        logic       regdst;    // [4]
        logic       alusrc;    // [3]
        logic [2:0] aluop;     // [2:0]
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Per-cycle action chosen by the hazard priority logic.
    typedef enum logic [1:0] {
        ACT_NORMAL  = 2'd0,
        ACT_LOADUSE = 2'd1,
        ACT_HOLD    = 2'd2,
        ACT_FLUSH   = 2'd3
    } act_e;

    function automatic logic uses_rs(input logic [5:0] op);
        return (op != OP_J) && (op != OP_JAL);
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/idex_hazard_reg_loaduse_detect.sv
// Combinational load-use detector: the instruction in ID reads a register
// that the load currently in EX has not yet produced.
module loaduse_detect
    import idex_hazard_reg_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    input  logic       i_idex_memrd,
    input  logic [4:0] i_idex_rt,
    output logic       o_loaduse
);

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_dest_live;

    assign w_rs_hit    = uses_rs(i_op) && (i_idex_rt == i_rs);
    assign w_rt_hit    = uses_rt(i_op) && (i_idex_rt == i_rt);
    // $0 is hard-wired, so a load targeting it never creates a dependency.
    assign w_dest_live = (i_idex_rt != 5'd0);

    assign o_loaduse = i_idex_memrd && w_dest_live && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with flush, memory-busy freeze and load-use
// bubble insertion, plus a saturating count of load-use bubbles.
module idex_hazard_reg
    import idex_hazard_reg_pkg::*;
#(
    parameter int CNTW = 16
)
(
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      ifidins,
    input  logic [CTL_W-1:0] ifidctl,
    input  logic [31:0]      rd1,
    input  logic [31:0]      rd2,
    input  logic [31:0]      imm,
    input  logic             flush,
    input  logic             dmembusy,
    output logic             pcwrite,
    output logic             ifidwrite,
    output logic [31:0]      idexins,
    output logic [4:0]       idexrs,
    output logic [4:0]       idexrt,
    output logic [4:0]       idexrd,
    output logic [CTL_W-1:0] idexctl,
    output logic [31:0]      idexrd1,
    output logic [31:0]      idexrd2,
    output logic [31:0]      ideximm,
    output logic             idexvalid,
    output logic [CNTW-1:0]  stallcnt
);

    logic [31:0]     r_ins;
    ctl_t            r_ctl;
    logic [31:0]     r_rd1;
    logic [31:0]     r_rd2;
    logic [31:0]     r_imm;
    logic            r_valid;
    logic [CNTW-1:0] r_stallcnt;

    logic            w_loaduse;
    logic            w_front_en;
    act_e            w_act;

    loaduse_detect u_loaduse_detect (
        .i_op         (ifidins[31:26]),
        .i_rs         (ifidins[25:21]),
        .i_rt         (ifidins[20:16]),
        .i_idex_memrd (r_ctl.memrd),
        .i_idex_rt    (r_ins[20:16]),
        .o_loaduse    (w_loaduse)
    );

    // NOTE: every combinational output gets its default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_act = ACT_NORMAL;
        if (flush)
            w_act = ACT_FLUSH;
        else if (dmembusy)
            w_act = ACT_HOLD;
        else if (w_loaduse)
            w_act = ACT_LOADUSE;
    end

    // The front end keeps fetching on a flush so the branch target enters IF/ID.
    assign w_front_en = !rstn || (w_act == ACT_NORMAL) || (w_act == ACT_FLUSH);
    assign pcwrite    = w_front_en;
    assign ifidwrite  = w_front_en;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ins      <= '0;
            r_ctl      <= '0;
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_imm      <= '0;
            r_valid    <= 1'b0;
            r_stallcnt <= '0;
        end else begin
            unique case (w_act)
                ACT_NORMAL: begin
                    r_ins   <= ifidins;
                    r_ctl   <= ctl_t'(ifidctl);
                    r_rd1   <= rd1;
                    r_rd2   <= rd2;
                    r_imm   <= imm;
                    r_valid <= 1'b1;
                end
                ACT_LOADUSE: begin
                    // The bubble clears memrd, which is what ends the stall next cycle.
                    r_ins   <= '0;
                    r_ctl   <= '0;
                    r_valid <= 1'b0;
                    if (r_stallcnt != {CNTW{1'b1}})
                        r_stallcnt <= r_stallcnt + 1'b1;
                end
                ACT_FLUSH: begin
                    r_ins   <= '0;
                    r_ctl   <= '0;
                    r_valid <= 1'b0;
                end
                ACT_HOLD: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign idexins   = r_ins;
    assign idexrs    = r_ins[25:21];
    assign idexrt    = r_ins[20:16];
    assign idexrd    = r_ins[15:11];
    assign idexctl   = r_ctl;
    assign idexrd1   = r_rd1;
    assign idexrd2   = r_rd2;
    assign ideximm   = r_imm;
    assign idexvalid = r_valid;
    assign stallcnt  = r_stallcnt;

endmodule

// File: tb/tb_idex_hazard_reg.sv
// Directed scoreboard bench: the driver queues hand-computed expectations,
// a monitor compares them against both DUT instances every cycle.
module tb_idex_hazard_reg;

    localparam logic [31:0] LW8  = 32'h8C28_0000;  // lw  $8,0($1)
    localparam logic [31:0] LW0  = 32'h8C20_0000;  // lw  $0,0($1)
    localparam logic [31:0] LW9  = 32'h8D09_0000;  // lw  $9,0($8)
    localparam logic [31:0] ADD  = 32'h010A_4820;  // add $9,$8,$10
    localparam logic [31:0] ADD0 = 32'h0001_4820;  // add $9,$0,$1
    localparam logic [31:0] J8   = 32'h0900_0000;  // j, ins[25:21]=8
    localparam logic [31:0] SW8  = 32'hAC28_0000;  // sw  $8,0($1)
    localparam logic [8:0]  C_LW  = 9'h168;
    localparam logic [8:0]  C_ADD = 9'h112;
    localparam logic [8:0]  C_SW  = 9'h088;
    localparam logic [8:0]  C_J   = 9'h000;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] ifidins, rd1, rd2, imm;
    logic [8:0]  ifidctl;
    logic        flush, dmembusy;

    logic        pcwrite, ifidwrite, idexvalid;
    logic [31:0] idexins, idexrd1, idexrd2, ideximm;
    logic [4:0]  idexrs, idexrt, idexrd;
    logic [8:0]  idexctl;
    logic [15:0] stallcnt;

    logic        s_pcwrite, s_ifidwrite, s_idexvalid;
    logic [31:0] s_idexins, s_idexrd1, s_idexrd2, s_ideximm;
    logic [4:0]  s_idexrs, s_idexrt, s_idexrd;
    logic [8:0]  s_idexctl;
    logic [1:0]  s_stallcnt;

    typedef struct {
        string       name;
        logic        pcw;
        logic [31:0] ins;
        logic [8:0]  ctl;
        logic        valid;
        int          tag;
        logic [15:0] cnt;
        logic [1:0]  cnts;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;

    idex_hazard_reg #(.CNTW(16)) dut (
        .clk(clk), .rstn(rstn), .ifidins(ifidins), .ifidctl(ifidctl),
        .rd1(rd1), .rd2(rd2), .imm(imm), .flush(flush), .dmembusy(dmembusy),
        .pcwrite(pcwrite), .ifidwrite(ifidwrite), .idexins(idexins),
        .idexrs(idexrs), .idexrt(idexrt), .idexrd(idexrd), .idexctl(idexctl),
        .idexrd1(idexrd1), .idexrd2(idexrd2), .ideximm(ideximm),
        .idexvalid(idexvalid), .stallcnt(stallcnt)
    );

    // Narrow counter instance: reaching 2 stands in for a preset of all-ones minus one.
    idex_hazard_reg #(.CNTW(2)) dut_s (
        .clk(clk), .rstn(rstn), .ifidins(ifidins), .ifidctl(ifidctl),
        .rd1(rd1), .rd2(rd2), .imm(imm), .flush(flush), .dmembusy(dmembusy),
        .pcwrite(s_pcwrite), .ifidwrite(s_ifidwrite), .idexins(s_idexins),
        .idexrs(s_idexrs), .idexrt(s_idexrt), .idexrd(s_idexrd), .idexctl(s_idexctl),
        .idexrd1(s_idexrd1), .idexrd2(s_idexrd2), .ideximm(s_ideximm),
        .idexvalid(s_idexvalid), .stallcnt(s_stallcnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] op_a(input int t); return 32'h1000_0000 + 32'(t); endfunction
    function automatic logic [31:0] op_b(input int t); return 32'h2000_0000 + 32'(t); endfunction
    function automatic logic [31:0] op_i(input int t); return 32'h3000_0000 + 32'(t); endfunction

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", what, act, exp);
        end
    endtask

    // One cycle of stimulus plus the state expected after its rising edge.
    // e_tag names the step whose operands must be in ID/EX (-1: not checked).
    task automatic step(input string nm, input logic [31:0] ins, input logic [8:0] ctl,
                        input logic fl, input logic busy, input logic pcw,
                        input logic [31:0] e_ins, input logic [8:0] e_ctl, input logic e_valid,
                        input int e_tag, input logic [15:0] e_cnt, input logic [1:0] e_cnts);
        exp_t e;
        @(negedge clk);
        step_no++;
        ifidins  = ins;
        ifidctl  = ctl;
        flush    = fl;
        dmembusy = busy;
        rd1      = op_a(step_no);
        rd2      = op_b(step_no);
        imm      = op_i(step_no);
        e.name  = nm;
        e.pcw   = pcw;
        e.ins   = e_ins;
        e.ctl   = e_ctl;
        e.valid = e_valid;
        e.tag   = e_tag;
        e.cnt   = e_cnt;
        e.cnts  = e_cnts;
        q.push_back(e);
    endtask

    task automatic reset_checks(input string nm);
        check({nm, ".idexvalid"}, idexvalid, 0);
        check({nm, ".idexins"},   idexins,   0);
        check({nm, ".idexrs"},    idexrs,    0);
        check({nm, ".idexrt"},    idexrt,    0);
        check({nm, ".idexrd"},    idexrd,    0);
        check({nm, ".idexctl"},   idexctl,   0);
        check({nm, ".idexrd1"},   idexrd1,   0);
        check({nm, ".idexrd2"},   idexrd2,   0);
        check({nm, ".ideximm"},   ideximm,   0);
        check({nm, ".stallcnt"},  stallcnt,  0);
        check({nm, ".stallcnt_s"}, s_stallcnt, 0);
        check({nm, ".pcwrite"},   pcwrite,   1);
        check({nm, ".ifidwrite"}, ifidwrite, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && q.size() != 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drain", q.size(), 0);
    endtask

    // Monitor: combinational enables mid low phase, registers just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() != 0) begin
                e = q[0];
                check({e.name, ".pcwrite"},     pcwrite,   e.pcw);
                check({e.name, ".ifidwrite"},   ifidwrite, e.pcw);
                check({e.name, ".pcwrite_s"},   s_pcwrite, e.pcw);
                @(posedge clk);
                #1;
                e = q.pop_front();
                check({e.name, ".idexins"},   idexins,   e.ins);
                check({e.name, ".idexrs"},    idexrs,    e.ins[25:21]);
                check({e.name, ".idexrt"},    idexrt,    e.ins[20:16]);
                check({e.name, ".idexrd"},    idexrd,    e.ins[15:11]);
                check({e.name, ".idexctl"},   idexctl,   e.ctl);
                check({e.name, ".idexvalid"}, idexvalid, e.valid);
                check({e.name, ".stallcnt"},  stallcnt,  e.cnt);
                check({e.name, ".stallcnt_s"}, s_stallcnt, e.cnts);
                if (e.tag >= 0) begin
                    check({e.name, ".idexrd1"}, idexrd1, op_a(e.tag));
                    check({e.name, ".idexrd2"}, idexrd2, op_b(e.tag));
                    check({e.name, ".ideximm"}, ideximm, op_i(e.tag));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0; flush = 1'b0; dmembusy = 1'b1;
        ifidins = ADD; ifidctl = C_ADD;
        rd1 = 32'hDEAD_0001; rd2 = 32'hDEAD_0002; imm = 32'hDEAD_0003;
        #7;
        reset_checks("reset_init");
        #1;
        rstn = 1'b1;
        dmembusy = 1'b0;

        //    name           ins   ctl    fl busy pcw  e_ins e_ctl  val tag cnt cnts
        step("lw8_enter",    LW8,  C_LW,  0, 0,   1,   LW8,  C_LW,  1,  1,  0, 0);
        step("rs_stall",     ADD,  C_ADD, 0, 0,   0,   0,    0,     0, -1,  1, 1);
        step("add_enters",   ADD,  C_ADD, 0, 0,   1,   ADD,  C_ADD, 1,  3,  1, 1);
        step("lw0_enter",    LW0,  C_LW,  0, 0,   1,   LW0,  C_LW,  1,  4,  1, 1);
        step("r0_nostall",   ADD0, C_ADD, 0, 0,   1,   ADD0, C_ADD, 1,  5,  1, 1);
        step("lw8_enter2",   LW8,  C_LW,  0, 0,   1,   LW8,  C_LW,  1,  6,  1, 1);
        step("lw_rs_stall",  LW9,  C_LW,  0, 0,   0,   0,    0,     0, -1,  2, 2);
        step("lw9_enters",   LW9,  C_LW,  0, 0,   1,   LW9,  C_LW,  1,  8,  2, 2);
        step("lw8_after9",   LW8,  C_LW,  0, 0,   1,   LW8,  C_LW,  1,  9,  2, 2);
        step("j_nostall",    J8,   C_J,   0, 0,   1,   J8,   C_J,   1, 10,  2, 2);
        step("lw8_enter3",   LW8,  C_LW,  0, 0,   1,   LW8,  C_LW,  1, 11,  2, 2);
        step("lw_rt_ignore", LW8,  C_LW,  0, 0,   1,   LW8,  C_LW,  1, 12,  2, 2);
        step("sw_rt_stall",  SW8,  C_SW,  0, 0,   0,   0,    0,     0, -1,  3, 3);
        step("sw_enters",    SW8,  C_SW,  0, 0,   1,   SW8,  C_SW,  1, 14,  3, 3);
        step("lw8_enter4",   LW8,  C_LW,  0, 0,   1,   LW8,  C_LW,  1, 15,  3, 3);
        step("flush_lu",     ADD,  C_ADD, 1, 0,   1,   0,    0,     0, -1,  3, 3);
        step("lw8_enter5",   LW8,  C_LW,  0, 0,   1,   LW8,  C_LW,  1, 17,  3, 3);
        step("busy1",        ADD,  C_ADD, 0, 1,   0,   LW8,  C_LW,  1, 17,  3, 3);
        step("busy2",        ADD,  C_ADD, 0, 1,   0,   LW8,  C_LW,  1, 17,  3, 3);
        step("busy3",        ADD,  C_ADD, 0, 1,   0,   LW8,  C_LW,  1, 17,  3, 3);
        step("post_busy_lu", ADD,  C_ADD, 0, 0,   0,   0,    0,     0, -1,  4, 3);
        step("add_enters2",  ADD,  C_ADD, 0, 0,   1,   ADD,  C_ADD, 1, 22,  4, 3);
        step("lw8_enter6",   LW8,  C_LW,  0, 0,   1,   LW8,  C_LW,  1, 23,  4, 3);
        step("sat_stall",    ADD,  C_ADD, 0, 0,   0,   0,    0,     0, -1,  5, 3);
        step("lw8_enter7",   LW8,  C_LW,  0, 0,   1,   LW8,  C_LW,  1, 25,  5, 3);
        drain();

        // Reset in the middle of a load-use stall.
        @(negedge clk);
        ifidins = ADD; ifidctl = C_ADD; flush = 1'b0; dmembusy = 1'b0;
        #2;
        check("midstall.pcwrite_before_reset", pcwrite, 0);
        rstn = 1'b0;
        #1;
        reset_checks("midstall_reset");
        @(posedge clk);
        #1;
        reset_checks("reset_held");
        #2;
        rstn = 1'b1;

        step("post_reset",   ADD,  C_ADD, 0, 0,   1,   ADD,  C_ADD, 1, 26,  0, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
